// File: rtl/hdmi_rd_pkg.sv
// Shared types and constants for the HDMI read-side frame controller.
// HDMI_RD_PINGPONG_EN enables double-buffered frame reads.
package hdmi_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_FILL,
    ST_REQ,
    ST_WAIT_DONE
  } state_t;

  localparam int FRAME_WORDS_DEF = 921600;
  localparam int FRAME_BYTES     = 2 * FRAME_WORDS_DEF;
  localparam int UFLOW_W         = 16;
  localparam int WCNT_W          = 20;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser with a rising-edge pulse.
// The pulse is combinational from the synchroniser flops.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;

endmodule

// File: rtl/hdmi_rd_frame_ctrl.sv
// Read-side frame controller: vsync flush, burst reads, underflow count.
// HDMI_RD_PINGPONG_EN adds I_Wr_Buf_Sel and reads the idle buffer.
module hdmi_rd_frame_ctrl
  import hdmi_rd_pkg::*;
#(
  parameter int FRAME_WORDS  = FRAME_WORDS_DEF,
  parameter int BURST_LEN    = 128,
  parameter int FIFO_DEPTH   = 1024,
  parameter int LVL_W        = 11,
  parameter int ADDR_W       = 28,
  parameter int BASE_ADDR    = 0,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic               Pixl_CLK,
  input  logic               Rst_n,
  input  logic               I_VGA_Sync,
  input  logic [LVL_W-1:0]   I_Fifo_Level,
  input  logic               I_Fifo_Empty,
  input  logic               I_Fifo_Rd_En,
`ifdef HDMI_RD_PINGPONG_EN
  input  logic               I_Wr_Buf_Sel,
`endif
  output logic               O_Fifo_Rst,
  output logic               O_Rd_Req,
  output logic [ADDR_W-1:0]  O_Rd_Addr,
  output logic [7:0]         O_Rd_Len,
  input  logic               I_Rd_Ack,
  input  logic               I_Rd_Done,
  output logic               O_Frame_Start,
  output logic [UFLOW_W-1:0] O_Underflow_Cnt
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STEP =
    ADDR_W'(2 * BURST_LEN);
  localparam logic [WCNT_W-1:0] WORD_STEP =
    WCNT_W'(BURST_LEN);
  localparam logic [WCNT_W-1:0] FRAME_W =
    WCNT_W'(FRAME_WORDS);
  localparam logic [LVL_W-1:0] LVL_MAX =
    LVL_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [FC_W-1:0] FC_LAST =
    FC_W'(FLUSH_CYCLES - 1);

  state_t            state;
  logic [FC_W-1:0]   flush_cnt;
  logic [WCNT_W-1:0] words;
  logic              pending;
  logic              rise;
  logic              pend_n;
  logic              go_flush;
  logic [ADDR_W-1:0] frame_base;

  sync_edge_det u_vs (
    .clk   (Pixl_CLK),
    .rst_n (Rst_n),
    .d     (I_VGA_Sync),
    .rise  (rise)
  );

`ifdef HDMI_RD_PINGPONG_EN
  assign frame_base = I_Wr_Buf_Sel ? BASE :
    BASE + ADDR_W'(2 * FRAME_WORDS);
`else
  assign frame_base = BASE;
`endif

  assign O_Rd_Len = 8'(BURST_LEN - 1);
  assign pend_n   = pending | rise;

  // An edge during a burst waits for its done before flushing.
  always_comb begin
    go_flush = 1'b0;
    unique case (state)
      ST_IDLE, ST_FLUSH, ST_FILL:
        go_flush = rise;
      ST_REQ:
        go_flush = I_Rd_Ack & I_Rd_Done & pend_n;
      ST_WAIT_DONE:
        go_flush = I_Rd_Done & pend_n;
      default:
        go_flush = 1'b0;
    endcase
  end

  always_ff @(posedge Pixl_CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state           <= ST_IDLE;
      flush_cnt       <= '0;
      words           <= '0;
      pending         <= 1'b0;
      O_Fifo_Rst      <= 1'b1;
      O_Rd_Req        <= 1'b0;
      O_Rd_Addr       <= BASE;
      O_Frame_Start   <= 1'b0;
      O_Underflow_Cnt <= '0;
    end else begin
      O_Frame_Start <= 1'b0;

      if (I_Fifo_Rd_En && I_Fifo_Empty && !O_Fifo_Rst &&
          O_Underflow_Cnt != '1)
        O_Underflow_Cnt <= O_Underflow_Cnt + 1'b1;

      unique case (state)
        ST_IDLE: ;
        ST_FLUSH: begin
          if (flush_cnt == FC_LAST) begin
            O_Fifo_Rst <= 1'b0;
            state      <= ST_FILL;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        ST_FILL: begin
          if (words != FRAME_W &&
              I_Fifo_Level <= LVL_MAX) begin
            O_Rd_Req <= 1'b1;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (rise) pending <= 1'b1;
          if (I_Rd_Ack) begin
            O_Rd_Req <= 1'b0;
            if (I_Rd_Done) begin
              words     <= words + WORD_STEP;
              O_Rd_Addr <= O_Rd_Addr + ADDR_STEP;
              state     <= ST_FILL;
            end else begin
              state <= ST_WAIT_DONE;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (rise) pending <= 1'b1;
          if (I_Rd_Done) begin
            words     <= words + WORD_STEP;
            O_Rd_Addr <= O_Rd_Addr + ADDR_STEP;
            state     <= ST_FILL;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (go_flush) begin
        state         <= ST_FLUSH;
        flush_cnt     <= '0;
        words         <= '0;
        pending       <= 1'b0;
        O_Fifo_Rst    <= 1'b1;
        O_Rd_Req      <= 1'b0;
        O_Rd_Addr     <= frame_base;
        O_Frame_Start <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_rd_frame_ctrl.sv
// Directed bench for hdmi_rd_frame_ctrl: vector table plus
// hand-written sequences for frame walk, deferred flush, saturation.
module tb_hdmi_rd_frame_ctrl;

`ifdef HDMI_RD_PINGPONG_EN
  localparam int EB = 2 * 921600;
`else
  localparam int EB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b0;
  logic [10:0] lvl = '0;
  logic        empty = 1'b0;
  logic        rd_en = 1'b0;
  logic        ack = 1'b0;
  logic        done = 1'b0;
  logic        wr_buf_sel = 1'b0;
  logic        frst;
  logic        req;
  logic [27:0] addr;
  logic [7:0]  len;
  logic        fs;
  logic [15:0] uf;

  logic        uf_on = 1'b0;
  logic [15:0] uf_exp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hdmi_rd_frame_ctrl dut (
    .Pixl_CLK        (clk),
    .Rst_n           (rst_n),
    .I_VGA_Sync      (vs),
    .I_Fifo_Level    (lvl),
    .I_Fifo_Empty    (empty),
    .I_Fifo_Rd_En    (rd_en),
`ifdef HDMI_RD_PINGPONG_EN
    .I_Wr_Buf_Sel    (wr_buf_sel),
`endif
    .O_Fifo_Rst      (frst),
    .O_Rd_Req        (req),
    .O_Rd_Addr       (addr),
    .O_Rd_Len        (len),
    .I_Rd_Ack        (ack),
    .I_Rd_Done       (done),
    .O_Frame_Start   (fs),
    .O_Underflow_Cnt (uf)
  );

  // Saturating underflow model, enabled only while the FIFO is out of reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) uf_exp <= '0;
    else if (uf_on && uf_exp != 16'hFFFF) uf_exp <= uf_exp + 1'b1;
  end

  typedef struct {
    int          n;
    logic        vs;
    logic [10:0] lvl;
    logic        ack;
    logic        done;
    logic        rd;
    logic        em;
    logic        fs;
    logic        frst;
    logic        req;
    logic [27:0] addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int n, bit v, int l, bit a, bit d,
                              bit r, bit e, bit f, bit fr, bit q,
                              int ad);
    vec_t t;
    t.n = n; t.vs = v; t.lvl = 11'(l); t.ack = a; t.done = d;
    t.rd = r; t.em = e; t.fs = f; t.frst = fr; t.req = q;
    t.addr = 28'(ad);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_req(input int lim, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req && k < lim);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int bad;
    int guard;

    //      n  vs lvl  ak dn rd em  fs fr rq addr
    tbl.push_back(mk(10, 0, 0,   0, 0, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1,  1, 0,   0, 0, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1,  1, 0,   0, 0, 1, 1, 1, 1, 0, EB));
    tbl.push_back(mk(15, 1, 0,   0, 0, 1, 1, 0, 1, 0, EB));
    tbl.push_back(mk(1,  0, 0,   0, 0, 0, 0, 0, 0, 0, EB));
    tbl.push_back(mk(1,  0, 0,   0, 0, 0, 0, 0, 0, 1, EB));
    tbl.push_back(mk(3,  0, 0,   0, 0, 0, 0, 0, 0, 1, EB));
    tbl.push_back(mk(1,  0, 0,   1, 0, 0, 0, 0, 0, 0, EB));
    tbl.push_back(mk(3,  0, 0,   0, 0, 1, 0, 0, 0, 0, EB));
    tbl.push_back(mk(1,  0, 0,   0, 1, 0, 0, 0, 0, 0, EB + 256));
    tbl.push_back(mk(4,  0, 900, 0, 0, 0, 0, 0, 0, 0, EB + 256));
    tbl.push_back(mk(1,  0, 896, 0, 0, 0, 0, 0, 0, 1, EB + 256));
    tbl.push_back(mk(1,  0, 896, 1, 1, 0, 0, 0, 0, 0, EB + 512));
    tbl.push_back(mk(2,  0, 900, 0, 0, 0, 0, 0, 0, 0, EB + 512));
    tbl.push_back(mk(1,  0, 0,   0, 0, 0, 0, 0, 0, 1, EB + 512));
    tbl.push_back(mk(2,  0, 0,   0, 1, 0, 0, 0, 0, 1, EB + 512));
    tbl.push_back(mk(1,  0, 0,   1, 0, 0, 0, 0, 0, 0, EB + 512));
    tbl.push_back(mk(1,  0, 0,   0, 1, 0, 0, 0, 0, 0, EB + 768));
    tbl.push_back(mk(1,  0, 0,   0, 0, 0, 0, 0, 0, 1, EB + 768));

    repeat (3) @(negedge clk);
    chk("rst_frst", 32'(frst), 1);
    chk("rst_req", 32'(req), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_fs", 32'(fs), 0);
    chk("rst_uf", 32'(uf), 0);
    chk("rd_len", 32'(len), 127);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      for (int s = 0; s < tbl[i].n; s++) begin
        vs = tbl[i].vs; lvl = tbl[i].lvl;
        ack = tbl[i].ack; done = tbl[i].done;
        rd_en = tbl[i].rd; empty = tbl[i].em;
        @(negedge clk);
        chk($sformatf("v%0d.%0d_fs", i, s), 32'(fs), 32'(tbl[i].fs));
        chk($sformatf("v%0d.%0d_frst", i, s), 32'(frst),
            32'(tbl[i].frst));
        chk($sformatf("v%0d.%0d_req", i, s), 32'(req),
            32'(tbl[i].req));
        chk($sformatf("v%0d.%0d_addr", i, s), 32'(addr),
            32'(tbl[i].addr));
        chk($sformatf("v%0d.%0d_uf", i, s), 32'(uf), 0);
      end
    end
    ack = 0; done = 0; rd_en = 0; empty = 0; lvl = 0;

    // Five underflow cycles while a request is pending.
    uf_on = 1; rd_en = 1; empty = 1;
    repeat (5) @(negedge clk);
    uf_on = 0; rd_en = 0; empty = 0;
    @(negedge clk);
    chk("uf_five", 32'(uf), 5);

    // Walk the rest of the frame; underflows keep counting meanwhile.
    uf_on = 1; rd_en = 1; empty = 1;
    bad = 0;
    for (int b = 3; b < 7200; b++) begin
      if (!req) wait_req(8, k);
      if (!req) begin
        chk($sformatf("burst%0d_req_timeout", b), 32'(req), 1);
        break;
      end
      if (addr !== 28'(EB + b * 256)) bad++;
      if (b == 7199)
        chk("last_addr", 32'(addr), 32'(EB + 32'h1C1F00));
      ack = 1; done = 1;
      @(negedge clk);
      ack = 0; done = 0;
    end
    chk("addr_walk_errs", bad, 0);
    chk("uf_model_mid", 32'(uf), 32'(uf_exp));

    bad = 0;
    guard = 0;
    while (uf_exp != 16'hFFFF && guard < 70000) begin
      @(negedge clk);
      guard++;
      if (req) bad++;
    end
    repeat (6) begin
      @(negedge clk);
      if (req) bad++;
    end
    uf_on = 0; rd_en = 0; empty = 0;
    chk("no_req_after_frame", bad, 0);
    chk("uf_sat", 32'(uf), 32'hFFFF);
    chk("uf_model_sat", 32'(uf), 32'(uf_exp));

    // New frame: latency from vsync to frame start and first request.
    vs = 1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!fs && k < 6);
    chk("fs_latency", k, 2);
    vs = 0;
    wait_req(40, k);
    chk("req_latency", k, 17);
    chk("f2_addr", 32'(addr), 32'(EB));

    // Vsync during WAIT_DONE defers the flush until done.
    ack = 1;
    @(negedge clk);
    ack = 0;
    bad = 0;
    vs = 1;
    for (int s = 0; s < 6; s++) begin
      if (s == 3) vs = 0;
      @(negedge clk);
      if (fs || frst || req) bad++;
    end
    chk("deferred_no_flush", bad, 0);
    done = 1;
    @(negedge clk);
    done = 0;
    chk("deferred_fs", 32'(fs), 1);
    chk("deferred_frst", 32'(frst), 1);
    chk("deferred_addr", 32'(addr), 32'(EB));
    wait_req(40, k);
    chk("deferred_req_latency", k, 17);
    chk("deferred_req_addr", 32'(addr), 32'(EB));

    // Reset mid-burst; a late done is ignored.
    ack = 1;
    @(negedge clk);
    ack = 0;
    rst_n = 0;
    #1;
    chk("arst_req", 32'(req), 0);
    chk("arst_frst", 32'(frst), 1);
    chk("arst_addr", 32'(addr), 0);
    chk("arst_uf", 32'(uf), 0);
    @(negedge clk);
    rst_n = 1;
    done = 1;
    @(negedge clk);
    done = 0;
    repeat (2) @(negedge clk);
    chk("late_done_frst", 32'(frst), 1);
    chk("late_done_req", 32'(req), 0);
    chk("late_done_addr", 32'(addr), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
